// File: rtl/mio_pkg.sv
// Shared encodings for the memory/IO port arbiter: FSM state values and owner codes.
package mio_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   typedef enum logic [1:0] {
      StIdle   = IDLE,
      StAccess = ACCESS,
      StDone   = DONE
   } mio_state_e;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DEV = 1'b1;

endpackage

// File: rtl/mio_starve_cnt.sv
// Counts contested arbitrations lost by the device and forces a device win once the
// count reaches STARVE_MAX. Used by mio_bus_arbiter only when MIO_ARB_STARVE_EN is defined.
module mio_starve_cnt #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic contest,
   input  logic dev_granted,
   output logic force_dev
);

   logic [3:0] cnt_q, cnt_d;

   // A contested arbitration that the device does not win is a loss.
   always_comb begin
      cnt_d = cnt_q;
      if (dev_granted) begin
         cnt_d = '0;
      end else if (contest) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_dev = (cnt_q == 4'(STARVE_MAX));

endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares one memory/IO port between the CPU controller and a device master.
// Define MIO_ARB_STARVE_EN to add device starvation protection; otherwise strict CPU priority.
module mio_bus_arbiter
   import mio_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   input  logic              dev_req,
   input  logic              dev_we,
   input  logic [ADDR_W-1:0] dev_addr,
   input  logic [DATA_W-1:0] dev_wdata,
   output logic [DATA_W-1:0] dev_rdata,
   output logic              dev_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner
);

   localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   mio_state_e        state_q, state_d;
   logic [CNT_W-1:0]  lat_q, lat_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              owner_q, owner_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dev_rdata_q, dev_rdata_d;

   logic any_req;
   logic grant_dev;
   logic force_dev;

   assign any_req = cpu_req | dev_req;

`ifdef MIO_ARB_STARVE_EN
   logic contest;
   logic dev_granted;

   assign contest     = (state_q == StIdle) & cpu_req & dev_req;
   assign dev_granted = (state_q == StIdle) & grant_dev;

   mio_starve_cnt #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve_cnt (
      .clk        (clk),
      .reset      (reset),
      .contest    (contest),
      .dev_granted(dev_granted),
      .force_dev  (force_dev)
   );
`else
   assign force_dev = 1'b0;
`endif

   assign grant_dev = dev_req & (~cpu_req | force_dev);

   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      owner_d     = owner_q;
      cpu_rdata_d = cpu_rdata_q;
      dev_rdata_d = dev_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               owner_d = grant_dev ? OWN_DEV : OWN_CPU;
               we_d    = grant_dev ? dev_we : cpu_we;
               addr_d  = grant_dev ? dev_addr : cpu_addr;
               wdata_d = grant_dev ? dev_wdata : cpu_wdata;
               lat_d   = LAT_LOAD;
               state_d = StAccess;
            end
         end
         StAccess: begin
            lat_d = lat_q - CNT_W'(1);
            // Memory data is only valid in the final access cycle.
            if (lat_q == '0) begin
               if (!we_q) begin
                  if (owner_q == OWN_DEV) begin
                     dev_rdata_d = mem_rdata;
                  end else begin
                     cpu_rdata_d = mem_rdata;
                  end
               end
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         lat_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         owner_q     <= OWN_CPU;
         cpu_rdata_q <= '0;
         dev_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         owner_q     <= owner_d;
         cpu_rdata_q <= cpu_rdata_d;
         dev_rdata_q <= dev_rdata_d;
      end
   end

   // All outputs come from registers or the state decode, never from the request inputs.
   assign mem_en    = (state_q == StAccess);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign owner     = owner_q;
   assign cpu_ready = (state_q == StDone) & (owner_q == OWN_CPU);
   assign dev_ready = (state_q == StDone) & (owner_q == OWN_DEV);
   assign cpu_rdata = cpu_rdata_q;
   assign dev_rdata = dev_rdata_q;

endmodule
